// File: rtl/edge_event_arbiter_pkg.sv
// Shared types and helpers for the edge event arbiter.
//   edge_sel_t  : which input transition counts as an event
//   arb_state_t : scheduler states
//   rr_pick     : round-robin search over an eligibility vector
package edge_event_pkg;

  typedef enum logic [1:0] {
    EDGE_RISE   = 2'd0,
    EDGE_FALL   = 2'd1,
    EDGE_EITHER = 2'd2
  } edge_sel_t;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_t;

  localparam int unsigned MAX_CHANNELS = 16;

  // First set bit of eligible at or above ptr, wrapping at n (n <= 16).
  // The wrap is an explicit subtract so non-power-of-two n works.
  // Returns 0 when nothing is eligible; callers gate on |eligible.
  function automatic logic [3:0] rr_pick(input logic [15:0]  eligible,
                                         input logic [3:0]   ptr,
                                         input int unsigned  n);
    logic [3:0]  pick;
    logic        found;
    int unsigned idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_CHANNELS; i++) begin
      if (i < n) begin
        idx = 32'(ptr) + i;
        if (idx >= n) idx = idx - n;
        if (!found && eligible[idx[3:0]]) begin
          pick  = idx[3:0];
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/edge_event_arbiter_if.sv
// Consumer handshake for the edge event arbiter.
//   o_valid : event offered (arbiter -> consumer)
//   o_chan  : index of offered channel
//   i_ready : consumer accepts the offered event
interface edge_event_arbiter_if #(
  parameter int CW = 2
);
  logic          o_valid;
  logic [CW-1:0] o_chan;
  logic          i_ready;

  modport master (output o_valid, output o_chan, input i_ready);
  modport slave  (input o_valid, input o_chan, output i_ready);
endinterface

// File: rtl/edge_event_arbiter_event_capture.sv
// Per-channel event capture: history register, edge select, pending and
// sticky overflow flops.
//   clk, reset  : clock, synchronous active-high reset
//   i_pulse     : level input for this channel
//   i_accept    : this channel's event is being accepted this cycle
//   i_ovf_clr   : clear the overflow flag
//   o_pending   : one event waiting
//   o_overflow  : an event arrived while one was already waiting
module event_capture
  import edge_event_pkg::*;
#(
  parameter edge_sel_t EDGE = EDGE_RISE,
  parameter logic      INIT = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_pulse,
  input  logic i_accept,
  input  logic i_ovf_clr,
  output logic o_pending,
  output logic o_overflow
);

  logic prev_q;
  logic pending_q, pending_d;
  logic overflow_q, overflow_d;
  logic edge_det;

  always_comb begin
    edge_det = 1'b0;
    case (EDGE)
      EDGE_RISE:   edge_det =  i_pulse & ~prev_q;
      EDGE_FALL:   edge_det = ~i_pulse &  prev_q;
      EDGE_EITHER: edge_det =  i_pulse ^  prev_q;
      default:     edge_det = 1'b0;
    endcase
  end

  // An edge in the accept cycle re-arms pending rather than overflowing.
  // Overflow set has priority over clear.
  always_comb begin
    pending_d  = edge_det | (pending_q & ~i_accept);
    overflow_d = (edge_det & pending_q & ~i_accept) | (overflow_q & ~i_ovf_clr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q     <= INIT;
      pending_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      prev_q     <= i_pulse;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign o_pending  = pending_q;
  assign o_overflow = overflow_q;

endmodule

// File: rtl/edge_event_arbiter.sv
// Edge event arbiter: captures edges on CHANNELS status lines and offers
// them one at a time, round-robin, over a valid/ready handshake.
//   clk, reset  : clock, synchronous active-high reset
//   i_pulse     : level inputs, one per source
//   i_mask      : 1 = captured but not offered
//   evt         : handshake (o_valid, o_chan, i_ready)
//   o_pending   : per-channel pending flags
//   o_overflow  : sticky per-channel overflow flags
//   i_ovf_clr   : clears matching overflow bits
module edge_event_arbiter
  import edge_event_pkg::*;
#(
  parameter int        CHANNELS = 4,
  parameter edge_sel_t EDGE     = EDGE_RISE,
  parameter logic      INIT     = 1'b1,
  localparam int       CW       = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [CHANNELS-1:0]     i_pulse,
  input  logic [CHANNELS-1:0]     i_mask,
  edge_event_arbiter_if.master    evt,
  output logic [CHANNELS-1:0]     o_pending,
  output logic [CHANNELS-1:0]     o_overflow,
  input  logic [CHANNELS-1:0]     i_ovf_clr
);

  arb_state_t          state_q;
  logic                valid_q;
  logic [CW-1:0]       chan_q;
  logic [CW-1:0]       rr_ptr_q;
  logic [CHANNELS-1:0] pending;
  logic [CHANNELS-1:0] overflow;
  logic [CHANNELS-1:0] eligible;
  logic [CHANNELS-1:0] accept_vec;
  logic [15:0]         elig16;
  logic [3:0]          pick4;
  logic [CW-1:0]       pick_chan;
  logic [CW-1:0]       rr_ptr_d;
  logic                accept;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    event_capture #(
      .EDGE (EDGE),
      .INIT (INIT)
    ) u_cap (
      .clk        (clk),
      .reset      (reset),
      .i_pulse    (i_pulse[k]),
      .i_accept   (accept_vec[k]),
      .i_ovf_clr  (i_ovf_clr[k]),
      .o_pending  (pending[k]),
      .o_overflow (overflow[k])
    );
  end

  assign accept   = (state_q == OFFER) & valid_q & evt.i_ready;
  assign eligible = pending & ~i_mask;

  always_comb begin
    accept_vec = '0;
    if (accept) accept_vec[chan_q] = 1'b1;
  end

  always_comb begin
    elig16                 = '0;
    elig16[CHANNELS-1:0]   = eligible;
    pick4                  = rr_pick(elig16, 4'(rr_ptr_q), CHANNELS);
    pick_chan              = pick4[CW-1:0];
    rr_ptr_d               = (chan_q == CW'(CHANNELS - 1)) ? '0 : chan_q + 1'b1;
  end

  // Mask is only consulted when choosing; an offer in flight is never retracted.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      chan_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|eligible) begin
            chan_q  <= pick_chan;
            valid_q <= 1'b1;
            state_q <= OFFER;
          end
        end
        OFFER: begin
          if (accept) begin
            rr_ptr_q <= rr_ptr_d;
            valid_q  <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign evt.o_valid = valid_q;
  assign evt.o_chan  = chan_q;
  assign o_pending   = pending;
  assign o_overflow  = overflow;

endmodule
